// File: rtl/freq_div_ctrl_if.sv
// ----------------------------------------------------------------------------
// freq_div_ctrl_if
//   Configuration channel of the divided-clock controller: a valid/ready
//   request carrying a new divisor, plus a one-cycle rejection pulse.
//
//   cfg_valid    requester -> controller   request valid
//   cfg_divisor  requester -> controller   requested divisor (WIDTH bits)
//   cfg_ready    controller -> requester   controller can accept a request
//   cfg_error    controller -> requester   one-cycle pulse, divisor rejected
//
//   master : requester side (CPU / config logic)
//   slave  : controller side (freq_div_ctrl)
// ----------------------------------------------------------------------------
interface freq_div_ctrl_if #(
    parameter int unsigned WIDTH = 10
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_divisor;
    logic             cfg_ready;
    logic             cfg_error;

    modport master (
        output cfg_valid,
        output cfg_divisor,
        input  cfg_ready,
        input  cfg_error
    );

    modport slave (
        input  cfg_valid,
        input  cfg_divisor,
        output cfg_ready,
        output cfg_error
    );
endinterface

// File: rtl/freq_div_ctrl.sv
// ----------------------------------------------------------------------------
// freq_div_ctrl
//   Run-time controller for a divide-by-D clock divider. Owns the divide
//   counter, holds the active divisor, accepts new divisors over a
//   valid/ready channel and applies them only at period boundaries so the
//   divided clock never shows a runt or stretched phase. Start/stop of the
//   divided clock is sequenced by a graceful-stop state machine: dropping
//   enable lets the current period finish before the output parks low.
//
// Ports
//   clock_in        input clock, all logic on its rising edge
//   reset           synchronous, active-high reset
//   enable          level: 1 = run, 0 = stop at end of current period
//   cfg             configuration channel (freq_div_ctrl_if.slave)
//                     cfg_valid / cfg_divisor in, cfg_ready / cfg_error out
//   clock_out       divided clock, registered; high floor(D/2), low ceil(D/2)
//   period_tick     one-cycle pulse after each completed period
//   running         1 whenever the state machine is not STOPPED
//   active_divisor  divisor currently in use
// ----------------------------------------------------------------------------
module freq_div_ctrl #(
    parameter int unsigned      WIDTH           = 10,
    parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = 10'd2
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               enable,
    freq_div_ctrl_if.slave     cfg,
    output logic               clock_out,
    output logic               period_tick,
    output logic               running,
    output logic [WIDTH-1:0]   active_divisor
);

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           state_q,         state_d;
    logic [WIDTH-1:0] counter_q,       counter_d;
    logic [WIDTH-1:0] active_q,        active_d;
    logic             pending_valid_q, pending_valid_d;
    logic [WIDTH-1:0] pending_div_q,   pending_div_d;
    logic             clock_out_q,     clock_out_d;
    logic             tick_q,          tick_d;
    logic             error_q,         error_d;

    // ------------------------------------------------------------------
    // Derived combinational terms
    // ------------------------------------------------------------------
    logic             counting;     // counter advances this cycle
    logic [WIDTH-1:0] last_count;   // D-1, the wrap value
    logic [WIDTH-1:0] half_div;     // D>>1, high-phase length
    logic             wrap;         // final cycle of the current period
    logic             cfg_xfer;     // handshake completes this cycle
    logic             cfg_bad;      // requested divisor is unusable

    assign counting   = (state_q != STOPPED);
    assign last_count = active_q - WIDTH'(1);
    assign half_div   = active_q >> 1;
    assign wrap       = counting && (counter_q == last_count);
    assign cfg_xfer   = cfg.cfg_valid && !pending_valid_q;
    assign cfg_bad    = (cfg.cfg_divisor < WIDTH'(2));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q         <= STOPPED;
            counter_q       <= '0;
            active_q        <= DEFAULT_DIVISOR;
            pending_valid_q <= 1'b0;
            pending_div_q   <= '0;
            clock_out_q     <= 1'b0;
            tick_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            active_q        <= active_d;
            pending_valid_q <= pending_valid_d;
            pending_div_q   <= pending_div_d;
            clock_out_q     <= clock_out_d;
            tick_q          <= tick_d;
            error_q         <= error_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        counter_d       = counter_q;
        active_d        = active_q;
        pending_valid_d = pending_valid_q;
        pending_div_d   = pending_div_q;
        clock_out_d     = 1'b0;
        tick_d          = 1'b0;
        error_d         = 1'b0;

        // Output phase is derived from the counter value of this cycle, so
        // clock_out lags the counter by exactly one cycle.
        if (counting) begin
            clock_out_d = (counter_q < half_div);
        end
        tick_d = wrap;

        unique case (state_q)
            STOPPED: begin
                counter_d = '0;
                if (enable) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                counter_d = wrap ? '0 : counter_q + WIDTH'(1);
                if (!enable) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                counter_d = wrap ? '0 : counter_q + WIDTH'(1);
                // Re-enable wins over the final wrap: the period simply
                // carries on without any phase disturbance.
                if (enable) begin
                    state_d = RUNNING;
                end else if (wrap) begin
                    state_d = STOPPED;
                end
            end
            default: begin
                state_d   = STOPPED;
                counter_d = '0;
            end
        endcase

        // A pending divisor lands either immediately while stopped or on the
        // wrap cycle while counting; in both cases the counter is already
        // heading to 0, so the next period starts cleanly with the new D.
        if (pending_valid_q && (!counting || wrap)) begin
            active_d        = pending_div_q;
            pending_valid_d = 1'b0;
        end

        // Intake only when the slot is empty; apply and intake are therefore
        // mutually exclusive, and a request taken on a wrap cycle waits for
        // the following wrap.
        if (cfg_xfer) begin
            if (cfg_bad) begin
                error_d = 1'b1;
            end else begin
                pending_valid_d = 1'b1;
                pending_div_d   = cfg.cfg_divisor;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign clock_out      = clock_out_q;
    assign period_tick    = tick_q;
    assign running        = (state_q != STOPPED);
    assign active_divisor = active_q;
    assign cfg.cfg_ready  = !pending_valid_q;
    assign cfg.cfg_error  = error_q;

endmodule
